// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a one-cycle valid strobe
//
// Purpose:
//   Converts an asynchronous 8N1 serial line (1 start bit, 8 data bits LSB
//   first, 1 stop bit, no parity) into a parallel byte. Every bit is sampled
//   near its centre, so moderate edge skew or a stretched start bit is
//   tolerated.
//
// Ports:
//   clk            in   1  system clock, rising edge
//   reset          in   1  synchronous active-high reset (may be tied low)
//   rx_serial      in   1  asynchronous serial line, idle high
//   rx_data_valid  out  1  one-cycle pulse per frame with a good stop bit
//   rx_data        out  8  last correctly received byte, held until the next
//
// Parameters:
//   CLOCKS_PER_BIT  system clocks per serial bit (>= 4), default 868

module uart_rx #(
  parameter int CLOCKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       rx_data_valid,
  output logic [7:0] rx_data
);

  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  // Centre of the start bit measured from the detected falling edge; all
  // later samples are whole bit periods after this point.
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_t;

  // Declaration initialisers give the power-up state so the block works with
  // reset tied low.
  logic             r_rx_meta  = 1'b1;
  logic             r_rx_s     = 1'b1;
  state_t           r_state    = S_IDLE;
  logic [CNT_W-1:0] r_clk_cnt  = '0;
  logic [2:0]       r_bit_idx  = 3'd0;
  logic [7:0]       r_shift    = 8'h00;
  logic [7:0]       r_rx_data  = 8'h00;
  logic             r_rx_valid = 1'b0;

  logic w_cnt_half;
  logic w_cnt_last;

  assign w_cnt_half = (r_clk_cnt == HALF);
  assign w_cnt_last = (r_clk_cnt == LAST);

  assign rx_data_valid = r_rx_valid;
  assign rx_data       = r_rx_data;

  // Two-flop synchroniser. Resetting to 1 (idle) keeps a reset from looking
  // like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_serial;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      // Strobe defaults low so it can only ever be high for one cycle.
      r_rx_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= 3'd0;
          if (!r_rx_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_cnt_half) begin
            r_clk_cnt <= '0;
            // A line that is high again at mid-start was only a glitch.
            if (!r_rx_s) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_cnt_last) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= 3'd0;
              r_state   <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_cnt_last) begin
            r_clk_cnt <= '0;
            // A low stop bit is a framing error: drop the byte silently.
            if (r_rx_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end
            r_state <= S_CLEANUP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_CLEANUP: begin
          r_clk_cnt <= '0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_clk_cnt <= '0;
          r_bit_idx <= 3'd0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 868 and 16 clocks per bit

module tb_uart_rx;

  localparam int CPB_A = 868;
  localparam int CPB_B = 16;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       valid_a;
  logic       valid_b;
  logic [7:0] data_a;
  logic [7:0] data_b;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  uart_rx #(.CLOCKS_PER_BIT(CPB_A)) u_dut_a (
    .clk           (clk),
    .reset         (rst_a),
    .rx_serial     (rx_a),
    .rx_data_valid (valid_a),
    .rx_data       (data_a)
  );

  uart_rx #(.CLOCKS_PER_BIT(CPB_B)) u_dut_b (
    .clk           (clk),
    .reset         (rst_b),
    .rx_serial     (rx_b),
    .rx_data_valid (valid_b),
    .rx_data       (data_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit use_b, input logic v);
    if (use_b) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit use_b, input int cpb, input logic [7:0] d,
                            input int start_extra, input logic stop_v);
    set_line(use_b, 1'b0);
    wait_clks(cpb + start_extra);
    for (int i = 0; i < 8; i++) begin
      set_line(use_b, d[i]);
      wait_clks(cpb);
    end
    set_line(use_b, stop_v);
    wait_clks(cpb);
    set_line(use_b, 1'b1);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (valid_a) begin
      if (exp_a.size() == 0) check("a_unexpected_pulse", 32'd1, 32'd0);
      else                   check("a_rx_data", {24'd0, data_a}, {24'd0, exp_a.pop_front()});
      pulses_a++;
    end
    if (valid_b) begin
      if (exp_b.size() == 0) check("b_unexpected_pulse", 32'd1, 32'd0);
      else                   check("b_rx_data", {24'd0, data_b}, {24'd0, exp_b.pop_front()});
      pulses_b++;
    end
  end

  initial begin
    // Power-up state without any reset.
    wait_clks(3);
    check("a_init_data",  {24'd0, data_a}, 32'h00);
    check("a_init_valid", {31'd0, valid_a}, 32'd0);
    check("b_init_data",  {24'd0, data_b}, 32'h00);
    check("b_init_valid", {31'd0, valid_b}, 32'd0);

    // Nominal byte with a start bit stretched by 100 clocks.
    exp_a.push_back(8'h37);
    send_frame(1'b0, CPB_A, 8'h37, 100, 1'b1);
    wait_clks(1);
    check("nominal_data",   {24'd0, data_a}, 32'h37);
    check("nominal_pulses", pulses_a, 32'd1);

    // Back-to-back frames with exact bit times.
    exp_a.push_back(8'h00);
    exp_a.push_back(8'hFF);
    exp_a.push_back(8'hA5);
    send_frame(1'b0, CPB_A, 8'h00, 0, 1'b1);
    send_frame(1'b0, CPB_A, 8'hFF, 0, 1'b1);
    send_frame(1'b0, CPB_A, 8'hA5, 0, 1'b1);
    wait_clks(1);
    check("b2b_pulses", pulses_a, 32'd4);
    check("b2b_data",   {24'd0, data_a}, 32'hA5);

    // Glitch shorter than half a bit: no output, receiver returns to idle.
    rx_a = 1'b0;
    wait_clks(200);
    rx_a = 1'b1;
    wait_clks(1000);
    check("glitch_pulses", pulses_a, 32'd4);
    check("glitch_data",   {24'd0, data_a}, 32'hA5);
    exp_a.push_back(8'h96);
    send_frame(1'b0, CPB_A, 8'h96, 0, 1'b1);
    wait_clks(1);
    check("after_glitch_pulses", pulses_a, 32'd5);
    check("after_glitch_data",   {24'd0, data_a}, 32'h96);

    // Short bit period instance.
    exp_b.push_back(8'hC3);
    send_frame(1'b1, CPB_B, 8'hC3, 0, 1'b1);
    wait_clks(1);
    check("cpb16_data",   {24'd0, data_b}, 32'hC3);
    check("cpb16_pulses", pulses_b, 32'd1);

    // Framing error then a good frame.
    send_frame(1'b1, CPB_B, 8'h5A, 0, 1'b0);
    wait_clks(3 * CPB_B);
    check("framing_pulses", pulses_b, 32'd1);
    check("framing_data",   {24'd0, data_b}, 32'hC3);
    exp_b.push_back(8'h3C);
    send_frame(1'b1, CPB_B, 8'h3C, 0, 1'b1);
    wait_clks(1);
    check("after_framing_pulses", pulses_b, 32'd2);
    check("after_framing_data",   {24'd0, data_b}, 32'h3C);

    // Reset for one cycle in the middle of data bit 4 of 0x81; the frame is
    // abandoned and the line returns to idle together with the reset.
    begin
      logic [7:0] d;
      d = 8'h81;
      rx_b = 1'b0;
      wait_clks(CPB_B);
      for (int i = 0; i < 4; i++) begin
        rx_b = d[i];
        wait_clks(CPB_B);
      end
      rx_b = d[4];
      wait_clks(CPB_B / 2);
      rst_b = 1'b1;
      rx_b  = 1'b1;
      wait_clks(1);
      check("reset_valid", {31'd0, valid_b}, 32'd0);
      check("reset_data",  {24'd0, data_b}, 32'h00);
      rst_b = 1'b0;
      wait_clks(3 * CPB_B);
      check("reset_pulses", pulses_b, 32'd2);
      check("reset_data_held", {24'd0, data_b}, 32'h00);
    end
    exp_b.push_back(8'h42);
    send_frame(1'b1, CPB_B, 8'h42, 0, 1'b1);
    wait_clks(1);
    check("after_reset_data",   {24'd0, data_b}, 32'h42);
    check("after_reset_pulses", pulses_b, 32'd3);

    wait_clks(2 * CPB_B);
    check("a_sb_empty", exp_a.size(), 32'd0);
    check("b_sb_empty", exp_b.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: converts an asynchronous 8N1 serial line (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) into a parallel byte with a one-cycle valid strobe. It sits at the serial input of the design, between the board RX pin and the command/move-decoding logic. It runs on the 100 MHz system clock and defaults to 115200 baud.

## Interface
- CLOCKS_PER_BIT, default 868: system clocks per serial bit (100 MHz / 115200). Must be ≥ 4.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset. May be left tied low; the block must operate correctly with reset never asserted, starting from its initial register values.
- rx_serial  input  1  asynchronous serial line. Idle is high.
- rx_data_valid  output  1  one-cycle pulse when a byte with a valid stop bit has been received.
- rx_data  output  8  last correctly received byte; held until the next valid byte.

## Operation
- Input sync: rx_serial passes through two flip-flops (both initialised/reset to 1). All decisions use the second-stage output, rx_s.
- Bit counter: clock counter width $clog2(CLOCKS_PER_BIT); bit index 3 bits; shift register 8 bits.
- Mid-sample point: HALF = (CLOCKS_PER_BIT-1)/2 (433 at the default).
- States:
  - IDLE: counter = 0, bit index = 0. If rx_s = 0, go to START.
  - START: count clocks. When counter = HALF: if rx_s = 0, clear the counter and go to DATA; else (glitch) go to IDLE with no output change.
  - DATA: count to CLOCKS_PER_BIT-1, then sample rx_s into shift[bit index] (LSB first) and clear the counter. After bit index 7, go to STOP; otherwise increment the bit index.
  - STOP: count to CLOCKS_PER_BIT-1, then sample rx_s. If rx_s = 1, load rx_data with the shift register and assert rx_data_valid for exactly one cycle. If rx_s = 0 (framing error), rx_data is unchanged and no pulse is produced. Go to CLEANUP in both cases.
  - CLEANUP: one cycle. rx_data_valid is deasserted; go to IDLE.
- Every sample is therefore taken near mid-bit. This tolerates up to about ±45% of a bit of edge skew or misalignment. For example, a start bit stretched by 100 clocks still decodes correctly.
- A new start bit is recognised only from IDLE, so the line must be high in IDLE. A line stuck low after a framing error re-enters START immediately.

## Timing
- Reset values (also the initial values): state IDLE, counters 0, shift register 0, rx_data 8'h00, rx_data_valid 0, sync flops 1.
- Reset asserted mid-frame: next cycle is IDLE with reset values; the partial byte is discarded; rx_data returns to 0.
- The falling edge at rx_serial reaches rx_s 2 cycles later. START ends HALF+1 cycles after entry.
- Data bit k is sampled (HALF+1) + (k+1)·CLOCKS_PER_BIT cycles after START entry. The stop bit is sampled at k = 8.
- rx_data and rx_data_valid update on the clock edge that samples the stop bit. Total latency from the start-bit falling edge to valid is about 2 + 9.5 bit periods, well before the nominal end of the stop bit.
- rx_data_valid is high for exactly 1 cycle per good frame. It is never high during reset.
- Back-to-back frames (the next start bit immediately after the stop bit) must be received without loss.

## Test plan
- Nominal byte: reset low, send 0x37 with a start bit of 868 + 100 clocks, then 8 data bits LSB first and a stop bit at 868 clocks each. One cycle after the stop bit ends, rx_data = 0x37, and exactly one rx_data_valid pulse has been seen.
- Back-to-back 0x00, 0xFF, 0xA5 with exact 868-clock bits -> three valid pulses with rx_data 0x00, 0xFF, 0xA5 in order.
- Glitch: drive rx_serial low for 200 clocks, then high -> no valid pulse, state back to IDLE, rx_data unchanged.
- Framing error: send 0x5A with the stop bit = 0, then line high, then send 0x3C -> no pulse for 0x5A, rx_data stays at its previous value, then one pulse with rx_data = 0x3C.
- Reset mid-frame: assert reset for 1 cycle during data bit 4 of 0x81 -> rx_data = 0x00, no pulse, and a following full 0x42 frame decodes to 0x42.
- Parameter check: CLOCKS_PER_BIT = 16, send 0xC3 -> rx_data = 0xC3 with a single valid pulse.
